serial_frame_capture: RTL

- Downstream consumer of the 3-bit counter / 8-bit serial shift register stage.
- Samples that stage's parallel byte `serialout` whenever its carry `co` marks a completed 8-bit group (once per 8 enabled bits).
- Hunts for a sync byte, then collects a fixed-length frame of payload bytes into a 4-entry FIFO.
- The FIFO is read through a valid/ready handshake by the next consumer.

---
 rtl/serial_frame_capture_if.sv | 19 +
 rtl/serial_frame_capture.sv | 114 +++++++++++
 2 files changed

// File: rtl/serial_frame_capture_if.sv
// Output handshake for serial_frame_capture.
// Master presents FIFO head; slave accepts it with out_ready.
interface serial_frame_capture_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/serial_frame_capture.sv
// Sync-byte hunter that frames upstream shift-register bytes
// and queues the payload into a small FIFO with valid/ready output.
module serial_frame_capture #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         FRAME_LEN = 4,
  parameter int         DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          co,
  input  logic [7:0]                    serialout,
  serial_frame_capture_if.master        out_if,
  output logic                          in_frame,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [3:0]                    frame_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {HUNT, LOCK} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic            done_q, done_d;
  logic            inf_q, inf_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];

  logic bev, take, push, pop, full;

  always_comb begin
    bev     = co & enable & reset;
    pop     = (occ_q != '0) & out_if.out_ready;
    full    = occ_q == (AW+1)'(DEPTH);
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (bev && serialout == SYNC_BYTE) begin
          state_d = LOCK;
          cnt_d   = 4'd0;
        end
      end
      LOCK: begin
        if (bev) begin
          take  = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(FRAME_LEN - 1)) begin
            state_d = HUNT;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 4'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    // A full FIFO still accepts a byte if the head leaves this cycle.
    push   = take & (~full | pop);
    ovf_d  = ovf_q | (take & full & ~pop);
    inf_d  = state_d == LOCK;
    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    mem_d  = mem_q;
    if (push) mem_d[wptr_q] = serialout;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= HUNT;
      cnt_q   <= 4'd0;
      fcnt_q  <= 4'd0;
      done_q  <= 1'b0;
      inf_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
      inf_q   <= inf_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign out_if.out_valid = occ_q != '0;
  assign out_if.out_data  = (occ_q != '0) ? mem_q[rptr_q] : 8'h00;
  assign in_frame         = inf_q;
  assign frame_done       = done_q;
  assign overflow         = ovf_q;
  assign frame_count      = fcnt_q;

endmodule
